// File: rtl/aesl_deadlock_pkg.sv
// Shared types and width helpers for the AXI-Stream deadlock monitor.
// Related build option: AESL_DEADLOCK_STICKY_EN (consumed by the top module).
package aesl_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SUSPECT  = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_e;

    // Index/counter width: clog2 of the value, never narrower than one bit.
    function automatic int calc_width(input int value);
        int w;
        w = $clog2(value);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/aesl_deadlock_axis_monitor_if.sv
// Bundle of the monitored block/idle flags, the clear pulse and the deadlock report.
// Related build option: AESL_DEADLOCK_STICKY_EN (affects only the monitor behaviour).
interface aesl_deadlock_axis_monitor_if #(
    parameter int NUM_AXIS = 4,
    parameter int NUM_INST = 2
);
    import aesl_deadlock_pkg::*;

    localparam int IDX_W = calc_width(NUM_AXIS);

    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_INST-1:0] inst_idle_sigs;
    logic [NUM_INST-1:0] inst_block_sigs;
    logic                clear;
    logic [NUM_AXIS-1:0] axis_block_info;
    logic [IDX_W-1:0]    first_idx;
    logic                block;

    // Bench / parent side: drives the flags, consumes the report.
    modport master (
        output axis_block_sigs,
        output inst_idle_sigs,
        output inst_block_sigs,
        output clear,
        input  axis_block_info,
        input  first_idx,
        input  block
    );

    // Monitor side.
    modport slave (
        input  axis_block_sigs,
        input  inst_idle_sigs,
        input  inst_block_sigs,
        input  clear,
        output axis_block_info,
        output first_idx,
        output block
    );

endinterface

// File: rtl/aesl_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder used to name the first blocked channel.
// Related build option: AESL_DEADLOCK_STICKY_EN (not used here).
module aesl_deadlock_prio_enc
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 4,
    parameter int IDX_W    = calc_width(NUM_AXIS)
) (
    input  logic [NUM_AXIS-1:0] i_vec,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_valid
);

    // Scan upward; the first set bit wins and later bits are ignored.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_AXIS; i++) begin
            o_idx   = (i_vec[i] && !o_valid) ? IDX_W'(i) : o_idx;
            o_valid = o_valid | i_vec[i];
        end
    end

endmodule

// File: rtl/aesl_deadlock_axis_monitor.sv
// Deadlock monitor: declares deadlock after BLOCK_THRESH consecutive candidate cycles.
// Build option AESL_DEADLOCK_STICKY_EN: DEADLOCK is left only through clear or reset.
module aesl_deadlock_axis_monitor
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_AXIS     = 4,
    parameter int NUM_INST     = 2,
    parameter int BLOCK_THRESH = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    aesl_deadlock_axis_monitor_if.slave   bus
);

    localparam int IDX_W = calc_width(NUM_AXIS);
    localparam int CNT_W = calc_width(BLOCK_THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_THRESH - 1);

    logic [NUM_AXIS-1:0] w_axis_block;
    logic [NUM_INST-1:0] w_inst_idle;
    logic [NUM_INST-1:0] w_inst_block;
    logic                w_clear;
    logic                w_cand;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_load_snap;
    logic                w_clr_snap;

    logic [IDX_W-1:0]    w_enc_idx;
    logic                w_enc_valid;

    logic                r_block;
    logic [NUM_AXIS-1:0] r_axis_block_info;
    logic [IDX_W-1:0]    r_first_idx;

    assign w_axis_block = bus.axis_block_sigs;
    assign w_inst_idle  = bus.inst_idle_sigs;
    assign w_inst_block = bus.inst_block_sigs;
    assign w_clear      = bus.clear;

    // All instances idle means the region has finished, never a deadlock.
    assign w_cand = (|w_axis_block) & (|w_inst_block) & ~(&w_inst_idle);

    aesl_deadlock_prio_enc #(
        .NUM_AXIS (NUM_AXIS),
        .IDX_W    (IDX_W)
    ) u_prio_enc (
        .i_vec   (w_axis_block),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    // Next-state, persistence counter and snapshot control; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_snap = 1'b0;
        w_clr_snap  = 1'b0;
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_clr_snap  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_cand) begin
                        if (BLOCK_THRESH == 1) begin
                            w_state_nxt = ST_DEADLOCK;
                            w_load_snap = 1'b1;
                        end else begin
                            w_state_nxt = ST_SUSPECT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SUSPECT: begin
                    if (!w_cand) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        // Counter parks at its last value; it never passes BLOCK_THRESH-1.
                        w_state_nxt = ST_DEADLOCK;
                        w_load_snap = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_DEADLOCK: begin
`ifdef AESL_DEADLOCK_STICKY_EN
                    w_state_nxt = ST_DEADLOCK;
`else
                    if (!w_cand) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_clr_snap  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DEADLOCK;
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_clr_snap  = 1'b1;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered report: block flag plus the channel snapshot taken on DEADLOCK entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_block           <= 1'b0;
            r_axis_block_info <= '0;
            r_first_idx       <= '0;
        end else begin
            r_block <= (w_state_nxt == ST_DEADLOCK);
            if (w_clr_snap) begin
                r_axis_block_info <= '0;
                r_first_idx       <= '0;
            end else if (w_load_snap && w_enc_valid) begin
                r_axis_block_info <= w_axis_block;
                r_first_idx       <= w_enc_idx;
            end else begin
                r_axis_block_info <= r_axis_block_info;
                r_first_idx       <= r_first_idx;
            end
        end
    end

    assign bus.block           = r_block;
    assign bus.axis_block_info = r_axis_block_info;
    assign bus.first_idx       = r_first_idx;

endmodule

// File: tb/tb_aesl_deadlock_axis_monitor.sv
// Bench for aesl_deadlock_axis_monitor: two instances (threshold 4 and 1) against a run-length model.
// Expectations follow AESL_DEADLOCK_STICKY_EN when the bench is built with it.
module tb_aesl_deadlock_axis_monitor;

    localparam int THR_A = 4;
    localparam int THR_B = 1;
`ifdef AESL_DEADLOCK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    int         m_run   [2];
    logic       m_block [2];
    logic [3:0] m_info  [2];
    logic [1:0] m_idx   [2];

    aesl_deadlock_axis_monitor_if #(.NUM_AXIS(4), .NUM_INST(2)) bus_a ();
    aesl_deadlock_axis_monitor_if #(.NUM_AXIS(4), .NUM_INST(2)) bus_b ();

    aesl_deadlock_axis_monitor #(
        .NUM_AXIS(4), .NUM_INST(2), .BLOCK_THRESH(THR_A)
    ) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    aesl_deadlock_axis_monitor #(
        .NUM_AXIS(4), .NUM_INST(2), .BLOCK_THRESH(THR_B)
    ) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [3:0] iso;
        iso = v & (~v + 4'd1);
        return 2'($clog2(iso));
    endfunction

    function automatic int thr_of(input int k);
        return (k == 0) ? THR_A : THR_B;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k]   = 0;
            m_block[k] = 1'b0;
            m_info[k]  = 4'd0;
            m_idx[k]   = 2'd0;
        end
    endtask

    // Deadlock = at least threshold consecutive candidate cycles since the last clear/drop/reset.
    task automatic model_step(input logic [3:0] ax, input logic [1:0] idle,
                              input logic [1:0] blk, input logic clr);
        bit cand;
        cand = (ax != 4'd0) && (blk != 2'd0) && (idle != 2'b11);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_run[k] = 0; m_block[k] = 1'b0; m_info[k] = 4'd0; m_idx[k] = 2'd0;
            end else if (cand) begin
                m_run[k]++;
                if (!m_block[k] && m_run[k] >= thr_of(k)) begin
                    m_block[k] = 1'b1;
                    m_info[k]  = ax;
                    m_idx[k]   = lowest_set(ax);
                end
            end else begin
                m_run[k] = 0;
                if (!STICKY) begin
                    m_block[k] = 1'b0; m_info[k] = 4'd0; m_idx[k] = 2'd0;
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("a_block", 32'(bus_a.block),           32'(m_block[0]));
        check_eq("a_info",  32'(bus_a.axis_block_info), 32'(m_info[0]));
        check_eq("a_idx",   32'(bus_a.first_idx),       32'(m_idx[0]));
        check_eq("b_block", 32'(bus_b.block),           32'(m_block[1]));
        check_eq("b_info",  32'(bus_b.axis_block_info), 32'(m_info[1]));
        check_eq("b_idx",   32'(bus_b.first_idx),       32'(m_idx[1]));
    endtask

    task automatic drive(input logic [3:0] ax, input logic [1:0] idle,
                         input logic [1:0] blk, input logic clr);
        bus_a.axis_block_sigs = ax;  bus_b.axis_block_sigs = ax;
        bus_a.inst_idle_sigs  = idle; bus_b.inst_idle_sigs = idle;
        bus_a.inst_block_sigs = blk; bus_b.inst_block_sigs = blk;
        bus_a.clear           = clr; bus_b.clear           = clr;
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic cycle(input logic [3:0] ax, input logic [1:0] idle,
                         input logic [1:0] blk, input logic clr);
        drive(ax, idle, blk, clr);
        @(posedge clock);
        model_step(ax, idle, blk, clr);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        drive(4'd0, 2'b00, 2'b00, 1'b0);
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Steady block on channel 2: deadlock after the 4th edge.
        cycle(4'd0, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0100, 2'b00, 2'b01, 1'b0);
            if (i == 2) check_eq("steady_pre", 32'(bus_a.block), 32'd0);
        end
        check_eq("steady_block", 32'(bus_a.block), 32'd1);
        check_eq("steady_info", 32'(bus_a.axis_block_info), 32'h4);
        check_eq("steady_idx", 32'(bus_a.first_idx), 32'd2);

        // One dropped candidate cycle discards the accumulated count.
        cycle(4'd0, 2'b00, 2'b00, 1'b1);
        cycle(4'b0100, 2'b00, 2'b01, 1'b0);
        cycle(4'b0100, 2'b00, 2'b01, 1'b0);
        cycle(4'b0000, 2'b00, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0100, 2'b00, 2'b01, 1'b0);
            if (i == 2) check_eq("drop_pre", 32'(bus_a.block), 32'd0);
        end
        check_eq("drop_block", 32'(bus_a.block), 32'd1);

        // All instances idle: never a deadlock.
        cycle(4'd0, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1010, 2'b11, 2'b01, 1'b0);
        end
        check_eq("idle_block", 32'(bus_a.block), 32'd0);
        check_eq("idle_info", 32'(bus_a.axis_block_info), 32'd0);

        // Release after deadlock, then clear.
        cycle(4'd0, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) cycle(4'b1010, 2'b01, 2'b10, 1'b0);
        check_eq("rel_idx", 32'(bus_a.first_idx), 32'd1);
        cycle(4'd0, 2'b00, 2'b00, 1'b0);
        check_eq("rel_block", 32'(bus_a.block), STICKY ? 32'd1 : 32'd0);
        cycle(4'd0, 2'b00, 2'b00, 1'b1);
        check_eq("rel_clear", 32'(bus_a.block), 32'd0);

        // Clear on the threshold cycle wins; counting restarts afterwards.
        for (int i = 0; i < 3; i++) cycle(4'b0011, 2'b00, 2'b11, 1'b0);
        cycle(4'b0011, 2'b00, 2'b11, 1'b1);
        check_eq("clr_thr_block", 32'(bus_a.block), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0011, 2'b00, 2'b11, 1'b0);
            if (i == 2) check_eq("clr_thr_pre", 32'(bus_a.block), 32'd0);
        end
        check_eq("clr_thr_after", 32'(bus_a.block), 32'd1);

        // Asynchronous reset mid-deadlock, between edges.
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_a_block", 32'(bus_a.block), 32'd0);
        check_eq("arst_a_info", 32'(bus_a.axis_block_info), 32'd0);
        check_eq("arst_b_block", 32'(bus_b.block), 32'd0);
        check_eq("arst_a_idx", 32'(bus_a.first_idx), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(4'b1000, 2'b10, 2'b01, 1'b0);
        check_eq("thr1_b_block", 32'(bus_b.block), 32'd1);
        check_eq("thr1_b_idx", 32'(bus_b.first_idx), 32'd3);
        check_eq("thr1_a_block", 32'(bus_a.block), 32'd0);

        // Randomized traffic biased toward long candidate runs.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] ax;
            logic [1:0] idle;
            logic [1:0] blk;
            logic       clr;
            ax   = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            idle = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            blk  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            clr  = ($urandom_range(0, 39) == 0);
            cycle(ax, idle, blk, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
